// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two W-bit unsigned operands one nibble per clock. A single 4-bit adder
// slice is shared across all nibbles, and a carry register links consecutive
// steps. An accepted start latches the operands and carry_in. The design then
// spends NIBBLES cycles in ADD, writing one sum nibble per cycle. It spends one
// cycle in DONE with the done pulse high, and then returns to IDLE.
//
// Ports
//   clock      rising-edge system clock
//   reset      asynchronous, active-high reset
//   start      request a new addition (honoured only in IDLE)
//   operand_a  first addend  (W bits, sampled with start)
//   operand_b  second addend (W bits, sampled with start)
//   carry_in   carry into nibble 0 (sampled with start)
//   busy       high while the addition is in progress (state ADD)
//   done       one-cycle pulse; sum/carry_out are valid
//   sum        registered W-bit result
//   carry_out  registered carry out of the most significant nibble
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] operand_a,
    input  logic [4*NIBBLES-1:0] operand_b,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 carry_out
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] index;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_carry;

    logic             accept;
    logic             last_step;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == ADD) && (index == LAST_IDX);

    // The one shared adder slice. The nibble index selects which operand
    // digits feed it on this cycle.
    assign slice_a = a_reg[{index, 2'b00} +: 4];
    assign slice_b = b_reg[{index, 2'b00} +: 4];
    assign {slice_carry, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_reg};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case. If a
    // path leaves a signal unassigned, the tool infers a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (index == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. An abort by reset clears the partial sum, so no stale digits
    // survive into the next operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            index     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            // The carry chain is seeded from the new carry_in. Nothing carries
            // over from the previous operation.
            a_reg     <= operand_a;
            b_reg     <= operand_b;
            carry_reg <= carry_in;
            index     <= '0;
        end else if (state == ADD) begin
            sum[{index, 2'b00} +: 4] <= slice_sum;
            carry_reg                <= slice_carry;
            if (last_step) begin
                index     <= '0;
                carry_out <= slice_carry;
            end else begin
                index <= index + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed bench for nibble_serial_adder with NIBBLES = 4. A table of operand
// and expected-result records is run through a fixed-latency transaction task.
// Hand-written sequences then cover start during ADD/DONE, reset abort,
// back-to-back operations with start held high, and result hold in IDLE.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Called on a falling edge with the DUT in IDLE. Start is accepted at the
    // next rising edge (E0). Busy must be high for the NIB cycles after E0.
    // Done must be high in the cycle after E0+NIB and low in the cycle after.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input string tag);
        int busy_cycles;
        busy_cycles = 0;
        operand_a = a;
        operand_b = b;
        carry_in  = cin;
        start     = 1'b1;
        for (int k = 0; k < NIB; k++) begin
            @(negedge clock);
            if (busy && !done) busy_cycles++;
            start     = 1'b0;
            // The operands were latched at acceptance, so changing them here
            // must not affect the result.
            operand_a = ~a;
            operand_b = ~b;
            carry_in  = ~cin;
        end
        check({tag, " busy_cycles"}, busy_cycles, NIB);
        @(negedge clock);
        check({tag, " busy_done_at_done"}, {30'd0, busy, done}, 32'b01);
        check({tag, " sum"}, {16'd0, sum}, {16'd0, exp_sum});
        check({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, exp_cout});
        @(negedge clock);
        check({tag, " busy_done_after"}, {30'd0, busy, done}, 32'b00);
    endtask

    initial begin
        int           dcount;
        int           d_cyc[2];
        logic [W-1:0] d_sum[2];
        logic         d_cout[2];
        logic         overlap;
        logic [W-1:0] dsum;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

        start     = 1'b0;
        operand_a = '0;
        operand_b = '0;
        carry_in  = 1'b0;
        reset     = 1'b0;

        // Asynchronous reset: outputs clear before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("reset busy_done", {30'd0, busy, done}, 32'b00);
        check("reset sum", {16'd0, sum}, 32'h0);
        check("reset carry_out", {31'd0, carry_out}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven vectors. Vector 5 follows a carry-out of 1 with
        // carry_in 0, so a leftover carry would show up in its result.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                   $sformatf("vec%0d", i));
        end

        // Hold in IDLE: with start low, changing inputs must not disturb results.
        operand_a = 16'h5A5A;
        operand_b = 16'hA5A5;
        carry_in  = 1'b1;
        repeat (3) @(negedge clock);
        check("idle hold sum", {16'd0, sum}, 32'h0001);
        check("idle hold busy_done", {30'd0, busy, done}, 32'b00);

        // Start raised in the 2nd ADD cycle is ignored until IDLE.
        operand_a = 16'h1111;
        operand_b = 16'h1111;
        carry_in  = 1'b0;
        start     = 1'b1;
        @(negedge clock);              // after E0: ADD cycle 1
        start = 1'b0;
        @(negedge clock);              // after E1: ADD cycle 2
        start     = 1'b1;
        operand_a = 16'hAAAA;
        dcount    = 0;
        dsum      = '0;
        for (int k = 0; k < 3; k++) begin   // after E2, E3, E4
            @(negedge clock);
            if (done) begin
                dcount++;
                dsum = sum;
            end
        end
        @(negedge clock);              // after E5: back in IDLE
        if (done) dcount++;
        check("ign done_count", dcount, 1);
        check("ign sum", {16'd0, dsum}, 32'h2222);
        check("ign idle_gap busy_done", {30'd0, busy, done}, 32'b00);
        @(negedge clock);              // after E6: new op accepted
        check("ign accept busy", {31'd0, busy}, 32'h1);
        start = 1'b0;
        repeat (3) @(negedge clock);
        @(negedge clock);              // after E10
        check("ign op2 done", {30'd0, busy, done}, 32'b01);
        check("ign op2 sum", {16'd0, sum}, 32'hBBBB);
        @(negedge clock);

        // Set carry_out to 1, then abort an operation with reset in ADD cycle 3.
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "pre_rst");
        operand_a = 16'h9999;
        operand_b = 16'h9999;
        carry_in  = 1'b0;
        start     = 1'b1;
        @(negedge clock);              // after E0
        start = 1'b0;
        @(negedge clock);              // after E1
        @(negedge clock);              // after E2: ADD cycle 3
        check("abort partial sum", {16'd0, sum}, 32'h0032);
        #2 reset = 1'b1;
        #1;
        check("abort busy_done", {30'd0, busy, done}, 32'b00);
        check("abort sum", {16'd0, sum}, 32'h0);
        check("abort carry_out", {31'd0, carry_out}, 32'h0);
        dcount = 0;
        repeat (2) begin
            @(negedge clock);
            if (done) dcount++;
        end
        check("abort no_done", dcount, 0);
        reset = 1'b0;
        run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "post_rst");

        // Start held high for two operations: done pulses 6 cycles apart.
        operand_a = 16'hFFFF;
        operand_b = 16'h0001;
        carry_in  = 1'b0;
        start     = 1'b1;
        dcount    = 0;
        overlap   = 1'b0;
        d_cyc     = '{0, 0};
        d_sum     = '{16'h0, 16'h0};
        d_cout    = '{1'b0, 1'b0};
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                operand_a = 16'h0000;
                operand_b = 16'h0000;
                carry_in  = 1'b0;
            end
            if (busy && done) overlap = 1'b1;
            if (done) begin
                if (dcount < 2) begin
                    d_cyc[dcount]  = cyc;
                    d_sum[dcount]  = sum;
                    d_cout[dcount] = carry_out;
                end
                dcount++;
                if (dcount == 2) start = 1'b0;
            end
        end
        check("b2b done_count", dcount, 2);
        check("b2b first_done_cycle", d_cyc[0], 5);
        check("b2b done_spacing", d_cyc[1] - d_cyc[0], 6);
        check("b2b op1 sum", {16'd0, d_sum[0]}, 32'h0000);
        check("b2b op1 carry_out", {31'd0, d_cout[0]}, 32'h1);
        check("b2b op2 sum", {16'd0, d_sum[1]}, 32'h0000);
        check("b2b op2 carry_out", {31'd0, d_cout[1]}, 32'h0);
        check("b2b busy_done_overlap", {31'd0, overlap}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
